// File: rtl/uart_frame_parser.sv
// Receive-side framing stage: hunts for SYNC, collects a length-prefixed payload,
// verifies an 8-bit additive checksum and holds the frame for random-access reads.
module uart_frame_parser #(
    parameter logic [7:0] SYNC          = 8'hA5,
    parameter int         MAX_LEN       = 16,
    parameter int         TIMEOUT_TICKS = 480,
    parameter int         LW            = $clog2(MAX_LEN + 1),
    parameter int         AW            = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rx_done_tick,
    input  logic [7:0]    rx_data,
    input  logic          s_tick,
    output logic          frame_valid,
    output logic [LW-1:0] frame_len,
    input  logic          frame_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          err_chk,
    output logic          err_len,
    output logic          err_timeout,
    output logic          err_overrun
);

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] val);
        return acc + val;
    endfunction

    state_t          state_r, state_s;
    logic [7:0]      cnt_r, cnt_s;
    logic [7:0]      len_r, len_s;
    logic [7:0]      sum_r, sum_s;
    logic [15:0]     tmo_r, tmo_s;
    logic [7:0]      buf_r [MAX_LEN];
    logic            wr_en_s;
    logic            frame_valid_r, frame_valid_s;
    logic [LW-1:0]   frame_len_r, frame_len_s;
    logic            err_chk_r, err_chk_s;
    logic            err_len_r, err_len_s;
    logic            err_timeout_r, err_timeout_s;
    logic            err_overrun_r, err_overrun_s;
    logic            timeout_s;
    logic            len_bad_s;

    // A byte arriving with the terminal tick always wins over the timeout.
    assign timeout_s = s_tick && !rx_done_tick && (tmo_r == 16'(TIMEOUT_TICKS - 1));
    assign len_bad_s = (rx_data == 8'd0) || ({24'd0, rx_data} > 32'(MAX_LEN));

    // Next-state, datapath and error-pulse decode.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        len_s         = len_r;
        sum_s         = sum_r;
        wr_en_s       = 1'b0;
        frame_valid_s = frame_valid_r;
        frame_len_s   = frame_len_r;
        err_chk_s     = 1'b0;
        err_len_s     = 1'b0;
        err_timeout_s = 1'b0;
        err_overrun_s = 1'b0;
        case (state_r)
            ST_HUNT: begin
                if (rx_done_tick && (rx_data == SYNC)) begin
                    state_s = ST_LEN;
                end else begin
                    state_s = ST_HUNT;
                end
            end
            ST_LEN: begin
                if (rx_done_tick) begin
                    if (len_bad_s) begin
                        err_len_s = 1'b1;
                        state_s   = ST_HUNT;
                    end else begin
                        len_s   = rx_data;
                        sum_s   = rx_data;
                        cnt_s   = 8'd0;
                        state_s = ST_PAYLOAD;
                    end
                end else if (timeout_s) begin
                    err_timeout_s = 1'b1;
                    state_s       = ST_HUNT;
                end else begin
                    state_s = ST_LEN;
                end
            end
            ST_PAYLOAD: begin
                if (rx_done_tick) begin
                    wr_en_s = 1'b1;
                    sum_s   = sum8(sum_r, rx_data);
                    cnt_s   = cnt_r + 8'd1;
                    if (cnt_r == (len_r - 8'd1)) begin
                        state_s = ST_CHK;
                    end else begin
                        state_s = ST_PAYLOAD;
                    end
                end else if (timeout_s) begin
                    err_timeout_s = 1'b1;
                    state_s       = ST_HUNT;
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end
            ST_CHK: begin
                if (rx_done_tick) begin
                    if (rx_data == sum_r) begin
                        frame_valid_s = 1'b1;
                        frame_len_s   = len_r[LW-1:0];
                        state_s       = ST_HOLD;
                    end else begin
                        err_chk_s = 1'b1;
                        state_s   = ST_HUNT;
                    end
                end else if (timeout_s) begin
                    err_timeout_s = 1'b1;
                    state_s       = ST_HUNT;
                end else begin
                    state_s = ST_CHK;
                end
            end
            ST_HOLD: begin
                // On release, a coincident byte is judged as if already hunting.
                if (frame_ack) begin
                    frame_valid_s = 1'b0;
                    if (rx_done_tick && (rx_data == SYNC)) begin
                        state_s = ST_LEN;
                    end else begin
                        state_s = ST_HUNT;
                    end
                end else if (rx_done_tick) begin
                    err_overrun_s = 1'b1;
                    state_s       = ST_HOLD;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_HUNT;
            end
        endcase
    end

    // Inter-byte timer: runs only while a frame is being collected.
    always_comb begin
        tmo_s = tmo_r;
        if (rx_done_tick || (state_s != state_r) ||
            (state_r == ST_HUNT) || (state_r == ST_HOLD)) begin
            tmo_s = 16'd0;
        end else if (s_tick) begin
            tmo_s = tmo_r + 16'd1;
        end else begin
            tmo_s = tmo_r;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_HUNT;
            cnt_r         <= 8'd0;
            len_r         <= 8'd0;
            sum_r         <= 8'd0;
            tmo_r         <= 16'd0;
            frame_valid_r <= 1'b0;
            frame_len_r   <= '0;
            err_chk_r     <= 1'b0;
            err_len_r     <= 1'b0;
            err_timeout_r <= 1'b0;
            err_overrun_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            len_r         <= len_s;
            sum_r         <= sum_s;
            tmo_r         <= tmo_s;
            frame_valid_r <= frame_valid_s;
            frame_len_r   <= frame_len_s;
            err_chk_r     <= err_chk_s;
            err_len_r     <= err_len_s;
            err_timeout_r <= err_timeout_s;
            err_overrun_r <= err_overrun_s;
        end
    end

    // Payload buffer, cleared on reset so unread entries read as zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                buf_r[i] <= 8'd0;
            end
        end else if (wr_en_s) begin
            buf_r[cnt_r[AW-1:0]] <= rx_data;
        end else begin
            buf_r <= buf_r;
        end
    end

    // Zero-latency random-access read port.
    always_comb begin
        rd_data = 8'd0;
        if ({{(32-AW){1'b0}}, rd_addr} < 32'(MAX_LEN)) begin
            rd_data = buf_r[rd_addr];
        end else begin
            rd_data = 8'd0;
        end
    end

    assign frame_valid = frame_valid_r;
    assign frame_len   = frame_len_r;
    assign err_chk     = err_chk_r;
    assign err_len     = err_len_r;
    assign err_timeout = err_timeout_r;
    assign err_overrun = err_overrun_r;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: a byte-stream frame model is compared every
// cycle, with hand-computed literal expectations at the key points.
module tb_uart_frame_parser;

    localparam int         MAX_LEN = 16;
    localparam int         LW      = 5;
    localparam int         AW      = 4;
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         TMO     = 480;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rx_done_tick;
    logic [7:0]    rx_data;
    logic          s_tick;
    logic          frame_valid;
    logic [LW-1:0] frame_len;
    logic          frame_ack;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          err_chk;
    logic          err_len;
    logic          err_timeout;
    logic          err_overrun;

    uart_frame_parser dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .s_tick       (s_tick),
        .frame_valid  (frame_valid),
        .frame_len    (frame_len),
        .frame_ack    (frame_ack),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .err_chk      (err_chk),
        .err_len      (err_len),
        .err_timeout  (err_timeout),
        .err_overrun  (err_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rd_ptr = 0;

    // Model: frame-level view of the byte stream. m_col holds everything after SYNC.
    bit         m_hold, m_active, m_valid;
    int         m_len, m_ticks;
    logic [3:0] m_errs;          // {chk, len, timeout, overrun}
    int         m_col[$];
    logic [7:0] m_buf[MAX_LEN];
    bit         m_known[MAX_LEN];

    bit         c_valid;
    int         c_len;
    logic [3:0] c_errs;
    logic [7:0] c_buf[MAX_LEN];
    bit         c_known[MAX_LEN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 1'b0; m_active = 1'b0; m_valid = 1'b0;
        m_len = 0; m_ticks = 0; m_errs = 4'b0000;
        m_col.delete();
        for (int i = 0; i < MAX_LEN; i++) begin
            m_buf[i] = 8'd0;
            m_known[i] = 1'b1;
        end
    endtask

    task automatic commit();
        c_valid = m_valid; c_len = m_len; c_errs = m_errs;
        c_buf = m_buf; c_known = m_known;
    endtask

    task automatic model_step(input logic rx, input logic [7:0] d, input logic tk, input logic ak);
        int n, l, s;
        m_errs = 4'b0000;
        if (m_hold) begin
            if (ak) begin
                m_hold = 1'b0;
                m_valid = 1'b0;
            end else if (rx) begin
                m_errs[0] = 1'b1;
            end
        end
        if (!m_hold && rx) begin
            if (!m_active) begin
                if (d == SYNC) begin
                    m_active = 1'b1;
                    m_col.delete();
                    m_ticks = 0;
                end
            end else begin
                m_col.push_back(int'(d));
                m_ticks = 0;
                n = m_col.size();
                l = m_col[0];
                if (n == 1) begin
                    if (l == 0 || l > MAX_LEN) begin
                        m_errs[2] = 1'b1;
                        m_active = 1'b0;
                    end
                end else if (n <= l + 1) begin
                    m_buf[n-2] = d;
                    m_known[n-2] = 1'b1;
                end else begin
                    s = 0;
                    for (int i = 0; i < n - 1; i++) s += m_col[i];
                    if ((s % 256) == int'(d)) begin
                        m_valid = 1'b1;
                        m_len = l;
                        m_hold = 1'b1;
                    end else begin
                        m_errs[3] = 1'b1;
                        for (int i = 0; i < MAX_LEN; i++) m_known[i] = 1'b0;
                    end
                    m_active = 1'b0;
                end
            end
        end else if (m_active && tk) begin
            m_ticks++;
            if (m_ticks == TMO) begin
                m_errs[1] = 1'b1;
                m_active = 1'b0;
            end
        end
    endtask

    // One clock: apply inputs, advance the model, then adopt its result after the edge.
    task automatic cyc(input logic rx, input logic [7:0] d, input logic tk, input logic ak);
        rx_done_tick = rx; rx_data = d; s_tick = tk; frame_ack = ak;
        rd_addr = rd_ptr[AW-1:0];
        rd_ptr++;
        if (reset_n) model_step(rx, d, tk, ak);
        else model_reset();
        @(posedge clk);
        #1;
        commit();
    endtask

    task automatic send_n(input int n, input logic [47:0] v);
        for (int i = 0; i < n; i++) cyc(1'b1, v[8*(n-1-i) +: 8], 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic read_check(input string name, input int a, input logic [7:0] exp);
        rd_addr = a[AW-1:0];
        #1;
        check(name, rd_data, exp);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("frame_valid", frame_valid, c_valid);
            check("frame_len", frame_len, c_len);
            check("err_vec", {err_chk, err_len, err_timeout, err_overrun}, c_errs);
            if (c_known[rd_addr]) check("rd_data", rd_data, c_buf[rd_addr]);
        end
    end

    initial begin
        reset_n = 1'b0;
        rx_done_tick = 1'b0; rx_data = 8'h00; s_tick = 1'b0; frame_ack = 1'b0;
        rd_addr = '0;
        model_reset();
        commit();
        idle(3);
        check("rst_valid", frame_valid, 32'd0);
        check("rst_len", frame_len, 32'd0);
        check("rst_err", {err_chk, err_len, err_timeout, err_overrun}, 32'd0);
        read_check("rst_rd", 5, 8'h00);
        reset_n = 1'b1;
        idle(2);

        send_n(2, 48'h55_33);
        send_n(6, 48'hA5_03_11_22_33_69);
        check("good_valid", frame_valid, 32'd1);
        check("good_len", frame_len, 32'd3);
        read_check("good_rd0", 0, 8'h11);
        read_check("good_rd1", 1, 8'h22);
        read_check("good_rd2", 2, 8'h33);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("ack_valid", frame_valid, 32'd0);
        idle(1);

        send_n(5, 48'hA5_02_10_20_00);
        check("chk_err", err_chk, 32'd1);
        check("chk_valid", frame_valid, 32'd0);
        idle(1);
        check("chk_err_once", err_chk, 32'd0);
        send_n(4, 48'hA5_01_7F_80);
        check("chk_next_valid", frame_valid, 32'd1);
        check("chk_next_len", frame_len, 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        send_n(2, 48'hA5_00);
        check("len_zero", err_len, 32'd1);
        send_n(2, 48'hA5_11);
        check("len_big", err_len, 32'd1);
        send_n(2, 48'hA5_A5);
        check("len_sync", err_len, 32'd1);
        idle(1);
        check("len_err_once", err_len, 32'd0);
        send_n(5, 48'hA5_02_01_02_05);
        check("len_next_valid", frame_valid, 32'd1);
        check("len_next_len", frame_len, 32'd2);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        send_n(3, 48'hA5_02_01);
        for (int i = 0; i < TMO - 1; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("to_early", err_timeout, 32'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("to_fire", err_timeout, 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        check("to_once", err_timeout, 32'd0);

        send_n(3, 48'hA5_02_01);
        for (int i = 0; i < TMO - 1; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h02, 1'b1, 1'b0);
        check("to_suppressed", err_timeout, 32'd0);
        send_n(1, 48'h05);
        check("to_frame_valid", frame_valid, 32'd1);
        check("to_frame_len", frame_len, 32'd2);

        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        check("ovr_pulse", err_overrun, 32'd1);
        check("ovr_len", frame_len, 32'd2);
        read_check("ovr_rd0", 0, 8'h01);
        read_check("ovr_rd1", 1, 8'h02);
        cyc(1'b1, 8'hA5, 1'b0, 1'b1);
        check("acksync_no_ovr", err_overrun, 32'd0);
        check("acksync_valid", frame_valid, 32'd0);
        send_n(3, 48'h01_7F_80);
        check("acksync_frame_valid", frame_valid, 32'd1);
        check("acksync_frame_len", frame_len, 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        send_n(3, 48'hA5_03_11);
        #2;
        reset_n = 1'b0;
        model_reset();
        commit();
        #1;
        check("midrst_valid", frame_valid, 32'd0);
        check("midrst_len", frame_len, 32'd0);
        read_check("midrst_rd0", 0, 8'h00);
        idle(2);
        reset_n = 1'b1;
        send_n(6, 48'hA5_03_11_22_33_69);
        check("post_rst_valid", frame_valid, 32'd1);
        check("post_rst_len", frame_len, 32'd3);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Receive-side framing stage directly downstream of the UART receiver. It consumes the receiver's one-cycle byte strobe and byte value, hunts for a sync byte, and collects a length-prefixed payload into an internal buffer. It then checks an 8-bit additive checksum and presents a complete, verified frame to the host logic through a random-access read port with a valid/ack handshake. The same 16x oversampling tick that drives the receiver is used here to time out stalled frames.

## Interface
- `SYNC`, 8'hA5: frame start byte.
- `MAX_LEN`, 16: maximum payload bytes; legal range 1..255.
- `TIMEOUT_TICKS`, 480: inter-byte timeout in `s_tick` pulses (3 byte times at 16x oversampling, 10 bits per byte).
- `LW`, $clog2(MAX_LEN+1): width of `frame_len`.
- `AW`, $clog2(MAX_LEN): width of `rd_addr`.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_done_tick`  in  1  one-cycle strobe: `rx_data` holds a new byte.
- `rx_data`  in  8  received byte; sampled only when `rx_done_tick`=1.
- `s_tick`  in  1  oversampling tick from the baud generator.
- `frame_valid`  out  1  verified frame held in buffer.
- `frame_len`  out  LW  payload length of the held frame.
- `frame_ack`  in  1  host releases the held frame.
- `rd_addr`  in  AW  buffer read address.
- `rd_data`  out  8  combinational read: `buf[rd_addr]`; 0 if `rd_addr` >= `MAX_LEN`.
- `err_chk`  out  1  one-cycle pulse: checksum mismatch.
- `err_len`  out  1  one-cycle pulse: illegal length byte.
- `err_timeout`  out  1  one-cycle pulse: inter-byte timeout.
- `err_overrun`  out  1  one-cycle pulse: byte dropped while a frame is held.

## Operation
- Frame format: `SYNC`, `LEN`, `LEN` payload bytes, `CHK`. A frame is good when `CHK` == (`LEN` + sum of payload) mod 256.
- Registers:
  - state
  - `cnt` (payload index)
  - `len_reg`
  - `sum_reg` (8 bits, wraps)
  - timeout counter (16 bits)
  - `buf[0..MAX_LEN-1]`
- FSM states and transitions. Every byte event below requires `rx_done_tick`=1.
  - HUNT: a byte equal to `SYNC` goes to LEN. Any other byte is silently discarded.
  - LEN: if the byte is 0 or greater than `MAX_LEN`, pulse `err_len` and go to HUNT. Otherwise set `len_reg`=byte, `sum_reg`=byte, `cnt`=0, and go to PAYLOAD. A `SYNC` value in this position is a length byte, not a resync.
  - PAYLOAD: write `buf[cnt]`=byte, add the byte to `sum_reg`, and increment `cnt`. When the written index equals `len_reg`-1, go to CHK.
  - CHK:
    - On a match, set `frame_len`=`len_reg` and `frame_valid`=1, and go to HOLD.
    - On a mismatch, pulse `err_chk` and go to HUNT. The buffer contents are then don't-care.
  - HOLD: the buffer is frozen and no writes occur.
    - A byte without `frame_ack` is dropped and pulses `err_overrun`.
    - `frame_ack`=1 goes to HUNT. If `rx_done_tick` arrives in the same cycle, that byte is evaluated as a HUNT byte: `SYNC` goes directly to LEN and there is no overrun pulse.
    - `frame_ack` outside HOLD is ignored.
- Timeout, active only in LEN, PAYLOAD and CHK:
  - The counter clears on entry to these states and on every `rx_done_tick`.
  - It increments on `s_tick`.
  - When `s_tick` arrives with the counter at `TIMEOUT_TICKS`-1, pulse `err_timeout` and go to HUNT.
  - If `rx_done_tick` and the terminal `s_tick` arrive in the same cycle, the byte wins and there is no timeout.
- At most one `err_*` pulse is asserted per cycle.
- Reset: state HUNT and all counters 0. The buffer is cleared to 0, so `rd_data` reads 0.

## Timing
- Reset values of outputs: `frame_valid`=0, `frame_len`=0, `rd_data`=0, and all `err_*`=0.
- All outputs are registered except `rd_data`, which is combinational from `rd_addr` with zero-cycle latency.
- `frame_valid` rises in the cycle after the `rx_done_tick` carrying a good `CHK`. The `err_*` pulses are likewise registered: high for exactly one cycle, in the cycle after the triggering event.
- `frame_valid` falls in the cycle after `frame_ack` is sampled high. `frame_len` holds its value until the next good frame.
- Back-to-back frames are accepted with no idle gap, except while HOLD blocks them.
- `rx_done_tick` arrives at most once every 160 `s_tick` pulses; the block does not rely on this spacing for correctness.

## Test plan
- Good frame: bytes A5, 03, 11, 22, 33, 69 → `frame_valid`=1 one cycle after the last byte, `frame_len`=3, and `rd_addr` 0/1/2 reads 11/22/33. Then `frame_ack` → `frame_valid`=0 in the next cycle.
- Checksum error: bytes A5, 02, 10, 20, 00 → one `err_chk` pulse and `frame_valid` stays 0. A following frame A5, 01, 7F, 80 → `frame_valid`=1 with `frame_len`=1.
- Length error and resync:
  - Bytes A5, 00 → one `err_len` pulse.
  - Bytes A5, 11 (17 > `MAX_LEN`) → one `err_len` pulse.
  - Bytes A5, A5 → one `err_len` pulse.
  - In every case the FSM is in HUNT and the next valid frame is accepted.
- Timeout: bytes A5, 02, 01, then silence for 480 `s_tick` → `err_timeout` pulses exactly once. A byte delivered together with the 480th tick suppresses the timeout.
- Overrun and simultaneous events:
  - While holding a frame, a byte 55 without ack → one `err_overrun` pulse, and the buffer and `frame_len` are unchanged.
  - Ack in the same cycle as an A5 byte → no overrun, and the FSM is in LEN.
- Reset mid-frame: assert `reset_n`=0 during PAYLOAD → all outputs 0 immediately and `rd_data`=0. After release, a full good frame is accepted.
